boom_release_arbiter: RTL
=========================

BOOM_RELEASE_ARBITER -- requirements
Module: boom_release_arbiter

Interface
REQ-001 Parameter DATA_W, default 128, width of one C-channel data beat in bits.
REQ-002 Parameter BEATS, default 4, number of beats in a data-carrying message (64-byte line at DATA_W=128).
REQ-003 Parameter REL_SOURCE, default 3'h0, TileLink source ID that marks this cache's voluntary releases on channel D.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-006 wb_valid/wb_ready  in/out  1/1  writeback-unit C-message handshake.
REQ-007 wb_opcode, wb_param, wb_size, wb_source, wb_address, wb_data  in  3,3,4,3,32,DATA_W  writeback-unit C fields.
REQ-008 pr_valid/pr_ready  in/out  1/1  probe-unit ProbeAck handshake; probe-unit messages carry no data.
REQ-009 pr_opcode, pr_param, pr_size, pr_source, pr_address  in  3,3,4,3,32  probe-unit C fields.
REQ-010 c_valid/c_ready  out/in  1/1  C-channel handshake to the L2.
REQ-011 c_opcode, c_param, c_size, c_source, c_address, c_data  out  3,3,4,3,32,DATA_W  C-channel fields.
REQ-012 d_valid, d_opcode, d_source  in  1,3,3  channel-D observation only; this block never drives d_ready.
REQ-013 mem_grant  out  1  one-cycle pulse per ReleaseAck addressed to REL_SOURCE.
REQ-014 busy  out  1  high whenever a multi-beat burst is in progress or the optional slice holds a beat.

Function
REQ-015 Opcodes 5 (ProbeAckData) and 7 (ReleaseData) SHALL be BEATS-beat messages; opcodes 4 (ProbeAck) and 6 (Release) SHALL be single-beat messages.
REQ-016 The FSM SHALL have exactly two states: ARB and WB_BURST.
REQ-017 In ARB, a valid writeback message SHALL take priority over a valid probe message, and the grant SHALL be decided combinationally in the same cycle.
REQ-018 In ARB, the granted source's ready SHALL equal c_ready and the other source's ready SHALL be 0; c_data SHALL be 0 for probe messages.
REQ-019 A fired writeback beat with a data opcode in ARB SHALL set beat_cnt to 1 and move the FSM to WB_BURST.
REQ-020 In WB_BURST, only the writeback source SHALL be granted and pr_ready SHALL be held at 0.
REQ-021 Each fired beat in WB_BURST SHALL increment beat_cnt; the beat that fires with beat_cnt==BEATS-1 SHALL return the FSM to ARB and clear beat_cnt, with no wrap-around.
REQ-022 beat_cnt SHALL be $clog2(BEATS) bits wide and SHALL be unsigned.
REQ-023 A probe message that arrives during WB_BURST SHALL be stalled and SHALL NOT be dropped; it wins the first ARB cycle only if wb_valid is 0 in that cycle.
REQ-024 c_valid SHALL never fall while c_ready is 0, and c_* fields SHALL be stable while c_valid is high and c_ready is low.
REQ-025 mem_grant SHALL equal d_valid && d_opcode==3'h6 && d_source==REL_SOURCE, registered, with one-cycle latency.
REQ-026 When a ReleaseAck arrives in the same cycle as a C beat fires, both events SHALL take effect independently.

Reset
REQ-027 While reset is 0: FSM=ARB, beat_cnt=0, mem_grant=0, c_valid=0, busy=0, optional slice empty; ready outputs follow REQ-017 and REQ-018 from the reset state.
REQ-028 A reset asserted mid-burst SHALL abandon the burst immediately; the first message after reset is arbitrated from ARB.

Configuration
REQ-029 Macro RELEASE_ARB_SKID_EN: when defined, the C outputs SHALL pass through a 2-entry skid slice, giving registered c_* outputs and 1 cycle of added latency while still sustaining one beat per cycle.
REQ-030 When RELEASE_ARB_SKID_EN is undefined, the C outputs SHALL be driven combinationally from the granted source with zero latency, and busy SHALL reflect the FSM state only.

Structure
REQ-031 Opcode constants (ProbeAck=4, ProbeAckData=5, Release=6, ReleaseData=7, ReleaseAck=6) and the C-message struct SHALL live in the shared tilelink package.
REQ-032 The skid slice SHALL be a separate sub-module, tl_c_skid, instantiated only under RELEASE_ARB_SKID_EN.

Verification
REQ-033 wb ReleaseData 0x8000_1040 with 4 beats, c_ready=1 throughout -> 4 consecutive c beats with data in order; FSM returns to ARB after beat 3.
REQ-034 pr ProbeAck param=1 asserted at beat 1 of a wb burst -> pr_ready=0 until the burst ends; the ProbeAck fires in the first ARB cycle.
REQ-035 wb Release (opcode 6) and pr ProbeAck asserted in the same cycle -> wb fires first as a single beat; pr fires the next cycle.
REQ-036 c_ready toggles 1,0,1,0 during a burst -> c_* fields held stable and exactly 4 beats delivered.
REQ-037 D ReleaseAck with source=REL_SOURCE, then one with source=3'h2 -> a single mem_grant pulse, one cycle after the first.
REQ-038 reset asserted after beat 2 of a burst -> FSM=ARB and beat_cnt=0; a subsequent ProbeAck fires normally.

Source files
------------

// File: rtl/boom_release_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// boom_release_arbiter_pkg
// Shared TileLink definitions for the release arbiter:
//   - C/D channel opcode constants
//   - arbiter FSM state encoding
//   - C-message header struct (data travels beside it, its width is a
//     per-instance parameter)
//   - helper that classifies multi-beat (data-carrying) C opcodes
// ----------------------------------------------------------------------------
package boom_release_arbiter_pkg;

    localparam logic [2:0] TL_PROBE_ACK      = 3'd4;
    localparam logic [2:0] TL_PROBE_ACK_DATA = 3'd5;
    localparam logic [2:0] TL_RELEASE        = 3'd6;
    localparam logic [2:0] TL_RELEASE_DATA   = 3'd7;
    localparam logic [2:0] TL_RELEASE_ACK    = 3'd6;

    typedef enum logic [0:0] {
        ARB      = 1'b0,
        WB_BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [2:0]  source;
        logic [31:0] address;
    } tl_c_hdr_t;

    // True for the opcodes that carry a full line of data beats.
    function automatic logic tl_c_has_data(input logic [2:0] opcode);
        return (opcode == TL_PROBE_ACK_DATA) || (opcode == TL_RELEASE_DATA);
    endfunction

endpackage

// File: rtl/tl_c_skid.sv
// ----------------------------------------------------------------------------
// tl_c_skid
// Two-entry skid slice for a valid/ready stream. The output side is fully
// registered; the input ready comes straight from a flop, so the upstream
// combinational arbiter never sees a path from out_ready. Full throughput is
// kept by parking one beat in the skid entry when the output stalls.
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   in_valid/in_ready/in_payload     upstream stream
//   out_valid/out_ready/out_payload  downstream stream (registered)
//   occupied          high while either entry holds a beat
// ----------------------------------------------------------------------------
module tl_c_skid #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload,
    output logic         occupied
);

    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_q, main_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_q, skid_d;
    logic         fire_in_s;
    logic         fire_out_s;

    assign in_ready    = ~skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_payload = main_q;
    assign occupied    = main_valid_q | skid_valid_q;

    // Next-state for the output entry and the skid entry.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        fire_in_s    = in_valid & ~skid_valid_q;
        fire_out_s   = main_valid_q & out_ready;
        if (!main_valid_q || fire_out_s) begin
            // Output entry frees up: refill from the skid entry first
            // (no input can fire then, since in_ready is low), else from input.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = fire_in_s;
                main_d       = fire_in_s ? in_payload : main_q;
            end
        end else begin
            // Output stalled: an accepted beat is parked in the skid entry.
            if (fire_in_s) begin
                skid_valid_d = 1'b1;
                skid_d       = in_payload;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Slice registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/boom_release_arbiter.sv
// ----------------------------------------------------------------------------
// boom_release_arbiter
// Merges the writeback unit (Release/ReleaseData) and probe unit (ProbeAck)
// onto one TileLink C channel. Writeback wins in ARB; a data message locks the
// channel to writeback for BEATS beats. Also watches channel D and pulses
// mem_grant one cycle after each ReleaseAck addressed to REL_SOURCE.
// Ports:
//   clock, reset              rising-edge clock, async active-low reset
//   wb_*                      writeback-unit C message + handshake
//   pr_*                      probe-unit C message (no data) + handshake
//   c_*                       C channel toward L2
//   d_valid/d_opcode/d_source channel D observation only
//   mem_grant                 registered ReleaseAck pulse
//   busy                      burst in progress or skid slice occupied
// Build option: define RELEASE_ARB_SKID_EN to register the C outputs through
// the tl_c_skid slice (one cycle of added latency, full throughput).
// ----------------------------------------------------------------------------
module boom_release_arbiter
    import boom_release_arbiter_pkg::*;
#(
    parameter int         DATA_W     = 128,
    parameter int         BEATS      = 4,
    parameter logic [2:0] REL_SOURCE = 3'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [2:0]        wb_opcode,
    input  logic [2:0]        wb_param,
    input  logic [3:0]        wb_size,
    input  logic [2:0]        wb_source,
    input  logic [31:0]       wb_address,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              pr_valid,
    output logic              pr_ready,
    input  logic [2:0]        pr_opcode,
    input  logic [2:0]        pr_param,
    input  logic [3:0]        pr_size,
    input  logic [2:0]        pr_source,
    input  logic [31:0]       pr_address,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [2:0]        c_opcode,
    output logic [2:0]        c_param,
    output logic [3:0]        c_size,
    output logic [2:0]        c_source,
    output logic [31:0]       c_address,
    output logic [DATA_W-1:0] c_data,
    input  logic              d_valid,
    input  logic [2:0]        d_opcode,
    input  logic [2:0]        d_source,
    output logic              mem_grant,
    output logic              busy
);

    localparam int              CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam int              HDR_W   = $bits(tl_c_hdr_t);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             mem_grant_q, mem_grant_d;
    logic             pr_lock_q, pr_lock_d;

    logic              sel_wb_s;
    logic              wb_fire_s;
    logic              arb_valid_s;
    logic              arb_ready_s;
    tl_c_hdr_t         arb_hdr_s;
    logic [DATA_W-1:0] arb_data_s;
    logic              skid_busy_s;

    // Grant, source readies, next FSM state, beat counter and D-channel watch.
    always_comb begin
        sel_wb_s    = 1'b0;
        arb_valid_s = 1'b0;
        arb_hdr_s   = '0;
        arb_data_s  = '0;
        wb_ready    = 1'b0;
        pr_ready    = 1'b0;
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;

        case (state_q)
            // A probe that was offered but stalled keeps the grant so the
            // C fields cannot change under a held c_valid.
            ARB:      sel_wb_s = wb_valid & ~pr_lock_q;
            WB_BURST: sel_wb_s = 1'b1;
            default:  sel_wb_s = 1'b0;
        endcase

        if (sel_wb_s) begin
            arb_valid_s = wb_valid;
            arb_hdr_s   = '{opcode: wb_opcode, param: wb_param, size: wb_size,
                            source: wb_source, address: wb_address};
            arb_data_s  = wb_data;
            wb_ready    = arb_ready_s;
            pr_ready    = 1'b0;
        end else begin
            arb_valid_s = pr_valid;
            arb_hdr_s   = '{opcode: pr_opcode, param: pr_param, size: pr_size,
                            source: pr_source, address: pr_address};
            arb_data_s  = '0;
            wb_ready    = 1'b0;
            pr_ready    = arb_ready_s;
        end

        wb_fire_s = sel_wb_s & wb_valid & arb_ready_s;

        case (state_q)
            ARB: begin
                if (wb_fire_s && tl_c_has_data(wb_opcode)) begin
                    state_d    = WB_BURST;
                    beat_cnt_d = CNT_W'(1);
                end else begin
                    state_d    = ARB;
                    beat_cnt_d = '0;
                end
            end
            WB_BURST: begin
                if (wb_fire_s) begin
                    if (beat_cnt_q == CNT_LAST) begin
                        state_d    = ARB;
                        beat_cnt_d = '0;
                    end else begin
                        state_d    = WB_BURST;
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = WB_BURST;
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = ARB;
                beat_cnt_d = '0;
            end
        endcase

        pr_lock_d   = (state_q == ARB) & ~sel_wb_s & pr_valid & ~arb_ready_s;
        mem_grant_d = d_valid & (d_opcode == TL_RELEASE_ACK) & (d_source == REL_SOURCE);
    end

    // FSM, beat counter, probe lock and mem_grant registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB;
            beat_cnt_q  <= '0;
            pr_lock_q   <= 1'b0;
            mem_grant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            pr_lock_q   <= pr_lock_d;
            mem_grant_q <= mem_grant_d;
        end
    end

`ifdef RELEASE_ARB_SKID_EN
    logic [HDR_W+DATA_W-1:0] skid_out_s;
    tl_c_hdr_t               skid_hdr_s;

    tl_c_skid #(
        .W (HDR_W + DATA_W)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (arb_valid_s),
        .in_ready    (arb_ready_s),
        .in_payload  ({arb_hdr_s, arb_data_s}),
        .out_valid   (c_valid),
        .out_ready   (c_ready),
        .out_payload (skid_out_s),
        .occupied    (skid_busy_s)
    );

    assign skid_hdr_s = skid_out_s[HDR_W+DATA_W-1:DATA_W];
    assign c_opcode   = skid_hdr_s.opcode;
    assign c_param    = skid_hdr_s.param;
    assign c_size     = skid_hdr_s.size;
    assign c_source   = skid_hdr_s.source;
    assign c_address  = skid_hdr_s.address;
    assign c_data     = skid_out_s[DATA_W-1:0];
`else
    assign arb_ready_s = c_ready;
    assign skid_busy_s = 1'b0;
    assign c_valid     = arb_valid_s;
    assign c_opcode    = arb_hdr_s.opcode;
    assign c_param     = arb_hdr_s.param;
    assign c_size      = arb_hdr_s.size;
    assign c_source    = arb_hdr_s.source;
    assign c_address   = arb_hdr_s.address;
    assign c_data      = arb_data_s;
`endif

    assign mem_grant = mem_grant_q;
    assign busy      = (state_q == WB_BURST) | skid_busy_s;

endmodule
